// File: rtl/ssem_pkg.sv
// Shared types for the SSEM sequenced datapath: opcodes, sequencer states and bus owners.
package ssem_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    LDI = 3'd1,
    MOV = 3'd2,
    ADD = 3'd3,
    SUB = 3'd4,
    NEG = 3'd5,
    TST = 3'd6,
    STO = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    EXEC = 2'd2
  } state_e;

  // One-hot so the bus is a plain AND-OR multiplexer
  typedef enum logic [2:0] {
    NONE = 3'b000,
    REG  = 3'b001,
    IMM  = 3'b010,
    ALU  = 3'b100
  } bus_owner_e;

  function automatic logic op_writes_dst(op_e op);
    return (op == LDI) || (op == MOV) || (op == ADD) || (op == SUB) || (op == NEG);
  endfunction

  function automatic logic op_updates_flags(op_e op);
    return (op == ADD) || (op == SUB) || (op == NEG) || (op == TST);
  endfunction

endpackage

// File: rtl/ssem_alu_n.sv
// Combinational add/subtract/negate ALU with zero, negative and signed-overflow flags.
module ssem_alu_n
  import ssem_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned MSB = WIDTH - 1;

  always_comb begin
    result = b;
    ovf    = 1'b0;
    case (op)
      ADD: begin
        result = a + b;
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      SUB: begin
        result = a - b;
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      NEG: begin
        result = '0 - b;
        // only the most negative value fails to negate
        ovf    = b[MSB] && result[MSB];
      end
      default: result = b;
    endcase
    zero = (result == '0);
    neg  = result[MSB];
  end

endmodule

// File: rtl/ssem_datapath_seq.sv
// SSEM register/ALU datapath with a three-phase micro-sequencer driving one shared internal bus.
module ssem_datapath_seq
  import ssem_pkg::*;
#(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned RW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [RW-1:0]    op_dst,
  input  logic [RW-1:0]    op_src,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             data_out_valid,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_ovf,
  output logic [WIDTH-1:0] bus_mon,
  input  logic [RW-1:0]    rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [RW-1:0]    dst_q, dst_d, src_q, src_d;
  logic [WIDTH-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic             done_q, done_d, dov_q, dov_d;

  bus_owner_e       owner_c;
  logic [WIDTH-1:0] bus_c, alu_res_c;
  logic             alu_zero_c, alu_neg_c, alu_ovf_c;

  ssem_alu_n #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res_c),
    .zero   (alu_zero_c),
    .neg    (alu_neg_c),
    .ovf    (alu_ovf_c)
  );

  // Bus owner and AND-OR bus multiplexer
  always_comb begin
    owner_c = NONE;
    case (state_q)
      OPER:    if (op_q == LDI) owner_c = IMM; else if (op_q != NOP) owner_c = REG;
      EXEC:    if (op_q != NOP) owner_c = ALU;
      default: owner_c = NONE;
    endcase
    bus_c = ({WIDTH{owner_c == REG}} & regs_q[src_q])
          | ({WIDTH{owner_c == IMM}} & imm_q)
          | ({WIDTH{owner_c == ALU}} & alu_res_c);
  end

  // Sequencer next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src_d    = src_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    regs_d   = regs_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    dov_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          op_d    = op_e'(op_code);
          dst_d   = op_dst;
          src_d   = op_src;
          imm_d   = data_in;
          state_d = OPER;
        end
      end
      OPER: begin
        if (op_q != NOP) begin
          b_d = bus_c;
          a_d = regs_q[dst_q];
        end
        state_d = EXEC;
      end
      EXEC: begin
        if (op_writes_dst(op_q)) regs_d[dst_q] = bus_c;
        if (op_q != NOP) result_d = bus_c;
        if (op_updates_flags(op_q)) begin
          zero_d = alu_zero_c;
          neg_d  = alu_neg_c;
          ovf_d  = alu_ovf_c;
        end
        done_d  = 1'b1;
        dov_d   = (op_q == STO);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= NOP;
      dst_q    <= '0;
      src_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      regs_q   <= '{default: '0};
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      dov_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      regs_q   <= regs_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      dov_q    <= dov_d;
    end
  end

  assign op_ready       = (state_q == IDLE);
  assign done           = done_q;
  assign data_out_valid = dov_q;
  assign result         = result_q;
  assign flag_zero      = zero_q;
  assign flag_neg       = neg_q;
  assign flag_ovf       = ovf_q;
  assign bus_mon        = bus_c;
  assign rd_data        = regs_q[rd_sel];

endmodule

// File: tb/tb_ssem_datapath_seq.sv
// Directed plus random operation sequence for ssem_datapath_seq, checked against an arithmetic reference model.
module tb_ssem_datapath_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic [1:0]  op_dst = 2'd0;
  logic [1:0]  op_src = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic        done;
  logic [31:0] result;
  logic        data_out_valid;
  logic        flag_zero, flag_neg, flag_ovf;
  logic [31:0] bus_mon;
  logic [1:0]  rd_sel = 2'd0;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [4];
  logic [31:0] m_result;
  logic        m_z, m_n, m_o;

  ssem_datapath_seq #(.WIDTH(32), .NUM_REGS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_code        (op_code),
    .op_dst         (op_dst),
    .op_src         (op_src),
    .data_in        (data_in),
    .done           (done),
    .result         (result),
    .data_out_valid (data_out_valid),
    .flag_zero      (flag_zero),
    .flag_neg       (flag_neg),
    .flag_ovf       (flag_ovf),
    .bus_mon        (bus_mon),
    .rd_sel         (rd_sel),
    .rd_data        (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
    m_result = 32'd0;
    m_z = 1'b0;
    m_n = 1'b0;
    m_o = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(op_ready), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dov"}, 32'(data_out_valid), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_flags"}, 32'({flag_zero, flag_neg, flag_ovf}), 32'd0);
    check({tag, "_bus"}, bus_mon, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      check({tag, "_reg"}, rd_data, 32'd0);
    end
  endtask

  // Issue one op at the current cycle (called #1 after a rising edge) and follow it to done
  task automatic do_op(input logic [2:0] c, input int d, input int s, input logic [31:0] imm);
    logic [31:0] r, oper_bus;
    longint      sa, sb, full;
    bit          ovf;
    check("ready_before", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_code  = c;
    op_dst   = 2'(d);
    op_src   = 2'(s);
    data_in  = imm;
    rd_sel   = 2'(d);

    sa  = longint'($signed(m_regs[d]));
    sb  = longint'($signed(m_regs[s]));
    r   = 32'd0;
    ovf = 1'b0;
    full = 0;
    case (c)
      3'd1:                r = imm;
      3'd2, 3'd6, 3'd7:    r = m_regs[s];
      3'd3:                full = sa + sb;
      3'd4:                full = sa - sb;
      3'd5:                full = -sb;
      default:             r = 32'd0;
    endcase
    if (c inside {3'd3, 3'd4, 3'd5}) begin
      r   = full[31:0];
      ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    end
    oper_bus = (c == 3'd0) ? 32'd0 : (c == 3'd1) ? imm : m_regs[s];

    @(posedge clk); #1;
    op_code = 3'($urandom);
    op_dst  = 2'($urandom);
    op_src  = 2'($urandom);
    data_in = $urandom;
    check("oper_ready", 32'(op_ready), 32'd0);
    check("oper_done", 32'(done), 32'd0);
    check("oper_bus", bus_mon, oper_bus);

    @(posedge clk); #1;
    data_in = $urandom;
    check("exec_ready", 32'(op_ready), 32'd0);
    check("exec_done", 32'(done), 32'd0);
    check("exec_dov", 32'(data_out_valid), 32'd0);
    check("exec_bus", bus_mon, r);

    if (c inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) m_regs[d] = r;
    if (c != 3'd0) m_result = r;
    if (c inside {3'd3, 3'd4, 3'd5, 3'd6}) begin
      m_z = (r == 32'd0);
      m_n = r[31];
      m_o = ovf;
    end

    @(posedge clk); #1;
    op_valid = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_ready", 32'(op_ready), 32'd1);
    check("done_dov", 32'(data_out_valid), 32'(c == 3'd7));
    check("done_result", result, m_result);
    check("done_flags", 32'({flag_zero, flag_neg, flag_ovf}), 32'({m_z, m_n, m_o}));
    check("done_rd", rd_data, m_regs[d]);
    check("done_bus", bus_mon, 32'd0);
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("por");

    // Load
    do_op(3'd1, 1, 0, 32'd5);
    // ADD with overflow
    do_op(3'd1, 1, 0, 32'h7FFF_FFFF);
    do_op(3'd1, 2, 0, 32'd1);
    do_op(3'd3, 1, 2, 32'hDEAD_BEEF);
    // SUB wrap-around, then NEG
    do_op(3'd1, 0, 0, 32'd0);
    do_op(3'd1, 3, 0, 32'd1);
    do_op(3'd4, 0, 3, 32'd0);
    do_op(3'd5, 2, 0, 32'd0);
    // Self-operand, TST, STO, NOP
    do_op(3'd1, 1, 0, 32'd6);
    do_op(3'd3, 1, 1, 32'd0);
    do_op(3'd1, 0, 0, 32'd0);
    do_op(3'd6, 3, 0, 32'd0);
    do_op(3'd7, 0, 1, 32'd0);
    @(posedge clk); #1;
    check("dov_single", 32'(data_out_valid), 32'd0);
    check("done_single", 32'(done), 32'd0);
    do_op(3'd0, 2, 3, 32'h1234_5678);
    // NEG of the most negative value
    do_op(3'd1, 3, 0, 32'h8000_0000);
    do_op(3'd5, 0, 3, 32'd0);

    // Random back-to-back operations
    for (int k = 0; k < 40; k++) begin
      logic [31:0] v;
      case ($urandom_range(3))
        0:       v = 32'h7FFF_FFFF;
        1:       v = 32'h8000_0000;
        default: v = $urandom;
      endcase
      do_op(3'($urandom), int'($urandom_range(3)), int'($urandom_range(3)), v);
    end

    // Reset during EXEC of LDI r2
    op_valid = 1'b1;
    op_code  = 3'd1;
    op_dst   = 2'd2;
    op_src   = 2'd0;
    data_in  = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    check_reset_state("midrst");
    @(posedge clk); #1;
    check("midrst_no_done", 32'(done), 32'd0);
    check("midrst_idle", 32'(op_ready), 32'd1);
    do_op(3'd1, 2, 0, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
